// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port, bounded bursts per grant tenure
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [IDX_W-1:0]              owner,
    output logic                          busy,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t state;
    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0] last_owner, start, winner;
    logic found, accept, last_beat, release_own;
    assign accept      = busy & req[owner] & ~full;
    assign fifo_w_en   = accept;
    assign fifo_w_data = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    assign last_beat   = beat_cnt == CNT_W'(MAX_BURST - 1);
    assign release_own = ~req[owner] | (accept & last_beat);
    assign start       = (state == OWN) ? owner : last_owner;
    // Scan downward so the nearest index after start wins; k=NUM_REQ wraps back to start itself
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(start) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(start) + k) % NUM_REQ);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else if (state == IDLE || release_own) begin
            if (state == OWN) last_owner <= owner;
            state    <= found ? OWN : IDLE;
            gnt      <= found ? NUM_REQ'(1) << winner : '0;
            owner    <= found ? winner : '0;
            busy     <= found;
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic checked against a cycle-level reference model
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          full = 1'b0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic [1:0]    owner;
    logic          busy, fifo_w_en;
    logic [DW-1:0] fifo_w_data;

    int n_cmp = 0, n_err = 0, n_wr = 0;
    int dcnt [N];
    int m_own = -1, m_last = N - 1, m_beat = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDX_W(2), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .full(full),
        .gnt(gnt), .owner(owner), .busy(busy), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data)
    );

    always #5 clk = ~clk;

    // Requester i presents word i*64 + (sequence number mod 64)
    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(i*64 + dcnt[i] % 64);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int s, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_last = N - 1;
        m_beat = 0;
    endtask

    // Apply inputs just after a falling edge, check outputs, then advance the model over the rising edge
    task automatic step(input logic [N-1:0] r, input logic f);
        logic ew;
        int   w, o;
        req = r;
        full = f;
        #1;
        o  = (m_own >= 0) ? m_own : 0;
        ew = (m_own >= 0) && r[o] && !f;
        chk("gnt", gnt, (m_own >= 0) ? (1 << m_own) : 0);
        chk("owner", owner, o);
        chk("busy", busy, m_own >= 0);
        chk("w_en", fifo_w_en, ew);
        chk("w_data", fifo_w_data, o*64 + dcnt[o] % 64);
        if (fifo_w_en) n_wr++;
        w = m_own;
        if (m_own < 0) begin
            m_own = pick(m_last, r);
            m_beat = 0;
        end else if (!r[m_own] || (ew && m_beat == MB - 1)) begin
            m_last = m_own;
            m_own = pick(m_own, r);
            m_beat = 0;
        end else if (ew) begin
            m_beat++;
        end
        @(negedge clk);
        if (ew) dcnt[w]++;
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_w_en"}, fifo_w_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) dcnt[i] = 0;
        @(negedge clk);
        @(negedge clk);
        pulse_reset("reset");
        // Lone requester: 4-beat burst, wrap-around re-grant with no bubble
        n_wr = 0;
        repeat (6) step(4'b0001, 1'b0);
        chk("t1_words", n_wr, 5);
        step(4'b0000, 1'b0);
        // All requesting: round-robin 0,1,2,3,0 with back-to-back writes
        pulse_reset("t2_rst");
        n_wr = 0;
        repeat (17) step(4'b1111, 1'b0);
        chk("t2_words", n_wr, 16);
        chk("t2_gnt", gnt, 4'b0001);
        // Requester 2 stalled by full for 3 cycles mid-burst
        pulse_reset("t3_rst");
        step(4'b0100, 1'b0);
        n_wr = 0;
        repeat (2) step(4'b0100, 1'b0);
        repeat (3) step(4'b0100, 1'b1);
        chk("t3_stall_words", n_wr, 2);
        chk("t3_gnt", gnt, 4'b0100);
        repeat (2) step(4'b0100, 1'b0);
        chk("t3_words", n_wr, 4);
        step(4'b0000, 1'b0);
        // Requester 1 drops after one write; requester 3 takes over
        step(4'b0010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        chk("t4_gnt", gnt, 4'b1000);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        // Requester 1 idles out; next grant starts after it
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        chk("t5_idle", busy, 0);
        step(4'b0101, 1'b0);
        chk("t5_gnt", gnt, 4'b0100);
        // Reset during requester 3's second beat
        repeat (5) step(4'b1111, 1'b0);
        chk("t6_owner", owner, 3);
        req = 4'b1111;
        pulse_reset("t6_rst");
        step(4'b1111, 1'b0);
        chk("t6_gnt", gnt, 4'b0001);
        // Random traffic with random back-pressure and occasional resets
        r = '0;
        repeat (600) begin
            if ($urandom_range(3) == 0) r = N'($urandom);
            if ($urandom_range(149) == 0) pulse_reset("rnd_rst");
            step(r, $urandom_range(3) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
